// File: rtl/ldpc_frame_io_ctrl.sv
// Host-side frame controller for the LDPC decoder: streams intrinsics into the PE array,
// waits for the decoder frame id to toggle, then reads hard decisions out per address.
module ldpc_frame_io_ctrl #(
  parameter int unsigned L             = 32,
  parameter int unsigned K             = 6,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned MESSAGE_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [MESSAGE_WIDTH-1:0] in_data,
  output logic                     in_ready,
  output logic                     en,
  output logic [K*K-1:0]           pe_select,
  output logic [MESSAGE_WIDTH-1:0] int_in,
  output logic [ADDR_WIDTH-1:0]    load_add_in,
  input  logic                     f_id,
  output logic [ADDR_WIDTH-1:0]    read_add_in,
  output logic [K-1:0]             column_select,
  input  logic [K*K-1:0]           dec_out_fin,
  output logic                     out_valid,
  output logic [K*K-1:0]           out_data,
  input  logic                     out_ready,
  output logic                     frame_done
);

  localparam int unsigned NumPe = K * K;
  localparam int unsigned PeW   = (NumPe > 1) ? $clog2(NumPe) : 1;
  localparam int unsigned ColW  = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    StLoad,
    StDecode,
    StRdCol,
    StRdCap,
    StOutWait
  } state_e;

  state_e state_q, state_d;

  // Load index n is kept split as (pe, row) = (n / L, n % L), avoiding any divider.
  logic [ADDR_WIDTH-1:0]    load_row_q, load_row_d;
  logic [PeW-1:0]           load_pe_q, load_pe_d;
  logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
  logic [ColW-1:0]          col_q, col_d;
  logic                     f_ref_q, f_ref_d;
  logic                     en_q, en_d;
  logic [NumPe-1:0]         pe_sel_q, pe_sel_d;
  logic [MESSAGE_WIDTH-1:0] int_q, int_d;
  logic [ADDR_WIDTH-1:0]    load_add_q, load_add_d;
  logic                     out_valid_q, out_valid_d;
  logic [NumPe-1:0]         out_data_q, out_data_d;
  logic                     frame_done_q, frame_done_d;

  logic in_hs;
  logic out_hs;
  logic load_last;

  assign in_ready  = (state_q == StLoad) && !rst;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign load_last = (load_pe_q == PeW'(NumPe - 1)) && (load_row_q == ADDR_WIDTH'(L - 1));

  always_comb begin
    state_d      = state_q;
    load_row_d   = load_row_q;
    load_pe_d    = load_pe_q;
    rd_addr_d    = rd_addr_q;
    col_d        = col_q;
    f_ref_d      = f_ref_q;
    en_d         = en_q;
    pe_sel_d     = '0;
    int_d        = int_q;
    load_add_d   = load_add_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (in_hs) begin
          pe_sel_d   = NumPe'(1) << load_pe_q;
          load_add_d = load_row_q;
          int_d      = in_data;
          en_d       = 1'b1;
          if (load_last) begin
            load_row_d = '0;
            load_pe_d  = '0;
            f_ref_d    = f_id;
            state_d    = StDecode;
          end else if (load_row_q == ADDR_WIDTH'(L - 1)) begin
            load_row_d = '0;
            load_pe_d  = load_pe_q + PeW'(1);
          end else begin
            load_row_d = load_row_q + ADDR_WIDTH'(1);
          end
        end
      end

      StDecode: begin
        if (f_id != f_ref_q) begin
          en_d      = 1'b0;
          rd_addr_d = '0;
          col_d     = '0;
          state_d   = StRdCol;
        end
      end

      StRdCol: begin
        if (col_q == ColW'(K - 1)) begin
          col_d   = '0;
          state_d = StRdCap;
        end else begin
          col_d = col_q + ColW'(1);
        end
      end

      StRdCap: begin
        // Decoder output settles one cycle after the last column strobe.
        out_data_d  = dec_out_fin;
        out_valid_d = 1'b1;
        state_d     = StOutWait;
      end

      StOutWait: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          col_d       = '0;
          if (rd_addr_q < ADDR_WIDTH'(L - 1)) begin
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            state_d   = StRdCol;
          end else begin
            rd_addr_d    = '0;
            frame_done_d = 1'b1;
            state_d      = StLoad;
          end
        end
      end

      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      load_row_q   <= '0;
      load_pe_q    <= '0;
      rd_addr_q    <= '0;
      col_q        <= '0;
      f_ref_q      <= 1'b0;
      en_q         <= 1'b0;
      pe_sel_q     <= '0;
      int_q        <= '0;
      load_add_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_row_q   <= load_row_d;
      load_pe_q    <= load_pe_d;
      rd_addr_q    <= rd_addr_d;
      col_q        <= col_d;
      f_ref_q      <= f_ref_d;
      en_q         <= en_d;
      pe_sel_q     <= pe_sel_d;
      int_q        <= int_d;
      load_add_q   <= load_add_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign en            = en_q;
  assign pe_select     = pe_sel_q;
  assign int_in        = int_q;
  assign load_add_in   = load_add_q;
  assign read_add_in   = rd_addr_q;
  assign column_select = (state_q == StRdCol) ? (K'(1) << col_q) : '0;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_ldpc_frame_io_ctrl.sv
// Self-checking bench for ldpc_frame_io_ctrl: random load streams, decode handoff,
// readout with backpressure, and mid-frame resets against a frame-level model.
module tb_ldpc_frame_io_ctrl;

  localparam int L    = 32;
  localparam int K    = 6;
  localparam int AW   = 5;
  localparam int MW   = 5;
  localparam int NPE  = K * K;
  localparam int NMSG = L * NPE;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [MW-1:0]   in_data;
  logic            in_ready;
  logic            en;
  logic [NPE-1:0]  pe_select;
  logic [MW-1:0]   int_in;
  logic [AW-1:0]   load_add_in;
  logic            f_id;
  logic [AW-1:0]   read_add_in;
  logic [K-1:0]    column_select;
  logic [NPE-1:0]  dec_out_fin;
  logic            out_valid;
  logic [NPE-1:0]  out_data;
  logic            out_ready;
  logic            frame_done;

  logic [NPE-AW-1:0] hd_tab [L];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Decoder stand-in: the hard-decision word for an address is a table entry tagged
  // with the address itself.
  assign dec_out_fin = {hd_tab[read_add_in], read_add_in};

  ldpc_frame_io_ctrl #(
    .L             (L),
    .K             (K),
    .ADDR_WIDTH    (AW),
    .MESSAGE_WIDTH (MW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .en            (en),
    .pe_select     (pe_select),
    .int_in        (int_in),
    .load_add_in   (load_add_in),
    .f_id          (f_id),
    .read_add_in   (read_add_in),
    .column_select (column_select),
    .dec_out_fin   (dec_out_fin),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .frame_done    (frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = '1;
    f_id      = 1'b0;
    out_ready = 1'b1;
    for (int a = 0; a < L; a++) hd_tab[a] = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_in_ready cycle=%0d got=%b exp=0", i, in_ready);
      end
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    checks++;
    if ({en, pe_select, int_in, load_add_in, read_add_in, column_select, out_valid, out_data,
         frame_done} !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs got=%h in_ready=%b exp=0 in_ready=1",
               {en, pe_select, int_in, load_add_in, read_add_in, column_select, out_valid,
                out_data, frame_done}, in_ready);
    end
  endtask

  // Streams one frame; every accepted message n must appear next cycle as a single write
  // to PE n/L, row n%L, and nothing is written on cycles without a handshake.
  task automatic load_frame(input int idle_pct, input bit ramp, input int toggle_at);
    int            n = 0;
    int            cyc = 0;
    int            pulses = 0;
    bit            hs;
    bit            toggled = 1'b0;
    logic [MW-1:0] cur;
    logic [MW-1:0] prev = '0;
    logic [NPE-1:0] exp_sel;
    while (n < NMSG && cyc < NMSG * 4 + 100) begin
      in_valid = ($urandom_range(0, 99) >= idle_pct);
      cur      = ramp ? MW'(n % L) : MW'($urandom);
      in_data  = cur;
      if (!toggled && n == toggle_at) begin
        f_id    = ~f_id;
        toggled = 1'b1;
      end
      hs = in_valid && in_ready;
      step();
      cyc++;
      if (pe_select !== '0) pulses++;
      checks++;
      if (hs) begin
        exp_sel = NPE'(1) << (n / L);
        if (pe_select !== exp_sel || load_add_in !== AW'(n % L) || int_in !== cur ||
            en !== 1'b1) begin
          failures++;
          $display("FAIL load_write n=%0d got sel=%h addr=%0d data=%0d en=%b exp sel=%h addr=%0d data=%0d en=1",
                   n, pe_select, load_add_in, int_in, en, exp_sel, n % L, cur);
        end
        prev = cur;
        n++;
      end else if (pe_select !== '0 ||
                   (n > 0 && (int_in !== prev || load_add_in !== AW'((n - 1) % L)))) begin
        failures++;
        $display("FAIL load_idle n=%0d got sel=%h data=%0d addr=%0d exp sel=0 data=%0d addr=%0d",
                 n, pe_select, int_in, load_add_in, prev, (n + L - 1) % L);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n != NMSG) begin
      failures++;
      $display("FAIL load_timeout accepted=%0d exp=%0d", n, NMSG);
    end
    checks++;
    if (pulses != NMSG) begin
      failures++;
      $display("FAIL load_pulses got=%0d exp=%0d", pulses, NMSG);
    end
    checks++;
    if (in_ready !== 1'b0 || en !== 1'b1) begin
      failures++;
      $display("FAIL load_end got in_ready=%b en=%b exp in_ready=0 en=1", in_ready, en);
    end
  endtask

  task automatic test_decode(input int wait_cycles);
    in_valid = 1'b1;
    for (int i = 0; i < wait_cycles; i++) begin
      step();
      checks++;
      if (column_select !== '0 || en !== 1'b1 || in_ready !== 1'b0 || pe_select !== '0) begin
        failures++;
        $display("FAIL decode_hold cycle=%0d got col=%b en=%b in_ready=%b sel=%h exp col=0 en=1 in_ready=0 sel=0",
                 i, column_select, en, in_ready, pe_select);
      end
    end
    in_valid = 1'b0;
    f_id     = ~f_id;
    step();
    checks++;
    if (column_select !== 6'b000001 || read_add_in !== '0 || en !== 1'b0) begin
      failures++;
      $display("FAIL decode_exit got col=%b addr=%0d en=%b exp col=000001 addr=0 en=0",
               column_select, read_add_in, en);
    end
  endtask

  // Entered with the first column strobe of address 0 visible. Word w is expected to
  // be accepted (K+2)*(w+1) cycles in, plus any deliberate stall on an earlier word.
  task automatic read_frame(input bit rand_hi, input int stall_word, input int stall_cycles);
    int             w = 0;
    int             cyc = 0;
    int             start = 0;
    int             stalled = 0;
    int             phase;
    int             exp_t;
    bit             hs;
    logic [NPE-1:0] exp_data;
    logic [K-1:0]   exp_col;
    for (int a = 0; a < L; a++) hd_tab[a] = rand_hi ? (NPE - AW)'($urandom) : '0;
    out_ready = 1'b1;
    while (w < L && cyc < L * (K + 2) + stall_cycles + 40) begin
      exp_data = {hd_tab[w], AW'(w)};
      phase    = cyc - start;
      checks++;
      if (out_valid === 1'b1) begin
        if (out_data !== exp_data || column_select !== '0) begin
          failures++;
          $display("FAIL out_word w=%0d got data=%h col=%b exp data=%h col=0",
                   w, out_data, column_select, exp_data);
        end
        if (w == stall_word && stalled < stall_cycles) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        exp_col = (phase < K) ? (K'(1) << phase) : '0;
        if (column_select !== exp_col || read_add_in !== AW'(w)) begin
          failures++;
          $display("FAIL read_sweep w=%0d phase=%0d got col=%b addr=%0d exp col=%b addr=%0d",
                   w, phase, column_select, read_add_in, exp_col, w);
        end
        out_ready = 1'b1;
      end
      checks++;
      if (frame_done !== 1'b0) begin
        failures++;
        $display("FAIL early_frame_done w=%0d got=%b exp=0", w, frame_done);
      end
      hs = out_valid && out_ready;
      step();
      cyc++;
      if (hs) begin
        exp_t = (K + 2) * (w + 1) + ((w >= stall_word) ? stall_cycles : 0);
        checks++;
        if (cyc != exp_t) begin
          failures++;
          $display("FAIL word_timing w=%0d got=%0d exp=%0d", w, cyc, exp_t);
        end
        w++;
        start = cyc;
      end
    end
    out_ready = 1'b1;
    checks++;
    if (w != L) begin
      failures++;
      $display("FAIL read_timeout words=%0d exp=%0d", w, L);
    end
    checks++;
    if (frame_done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_done_pulse got done=%b in_ready=%b valid=%b exp done=1 in_ready=1 valid=0",
               frame_done, in_ready, out_valid);
    end
    step();
    checks++;
    if (frame_done !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL frame_done_after got done=%b in_ready=%b exp done=0 in_ready=1",
               frame_done, in_ready);
    end
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_in_ready got=%b exp=0", tag, in_ready);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({en, pe_select, int_in, load_add_in, read_add_in, column_select, out_valid, out_data,
         frame_done} !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_outputs got=%h in_ready=%b exp=0 in_ready=1", tag,
               {en, pe_select, int_in, load_add_in, read_add_in, column_select, out_valid,
                out_data, frame_done}, in_ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc = 0;
    load_frame(10, 1'b0, -1);
    for (int i = 0; i < 4; i++) step();
    reset_pulse("rst_decode");

    load_frame(0, 1'b0, -1);
    test_decode(2);
    out_ready = 1'b1;
    while (!(read_add_in === AW'(10) && column_select !== '0) && cyc < 200) begin
      step();
      cyc++;
    end
    checks++;
    if (read_add_in !== AW'(10) || column_select === '0) begin
      failures++;
      $display("FAIL reach_addr10 got addr=%0d col=%b exp addr=10 col!=0",
               read_add_in, column_select);
    end
    reset_pulse("rst_rdcol");

    load_frame(30, 1'b0, -1);
    test_decode(7);
    read_frame(1'b1, L, 0);
  endtask

  initial begin
    test_reset();
    // Ramp frame, no stalls, unstalled readout of address-only words.
    load_frame(0, 1'b1, -1);
    test_decode(3);
    read_frame(1'b0, L, 0);
    // Idle gaps plus an f_id toggle during load, then backpressure on word 5.
    load_frame(30, 1'b1, 400);
    test_decode(50);
    read_frame(1'b1, 5, 20);
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
